ex_stage_muldiv: RTL and testbench
==================================

Name: ex_stage_muldiv

Overview:
- Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EX latch outputs and produces the registered EX/MEM latch contents.
- Contains the ALU, ALU-control decode, branch-target adder, destination-register mux, HI/LO registers and an iterative 32-cycle shift-add multiplier.
- While a MULT/MULTU is iterating it asserts stall_o to freeze PC, IF/ID and ID/EX, and inserts bubbles into EX/MEM.

Parameters:
- XLEN, 32, datapath width; the multiplier iteration count equals XLEN.
- CNT_W, 5, width of the iteration counter, equal to log2(XLEN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wb_in  in  2  WB control from ID/EX; [1]=RegWrite, [0]=MemtoReg.
- mem_in  in  3  MEM control from ID/EX; [2]=Branch, [1]=MemRead, [0]=MemWrite.
- ex_in  in  4  EX control; [3]=RegDst, [2:1]=ALUOp, [0]=ALUSrc.
- npc_in  in  32  PC+4.
- rd1_in  in  32  rs value.
- rd2_in  in  32  rt value.
- imm_in  in  32  sign-extended immediate.
- rt_in  in  5  instr[20:16].
- rd_in  in  5  instr[15:11].
- funct_in  in  6  instr[5:0].
- stall_o  out  1  freeze upstream stages; combinational.
- wb_out  out  2  registered WB control.
- mem_out  out  3  registered MEM control.
- br_tgt_out  out  32  npc_in + (imm_in<<2), mod 2^32.
- zero_out  out  1  ALU result == 0.
- alu_out  out  32  ALU / HI / LO result.
- rd2_out  out  32  rt value, used as store data.
- wreg_out  out  5  destination register.

Behaviour:
- Reset: every output register is 0, HI=LO=0, state IDLE, counter 0, stall_o=0.
- ALU B operand: imm_in if ALUSrc, else rd2_in.
- ALUOp 00 = add; 01 = sub; 11 = or.
- ALUOp 10 decodes funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed).
  - 010000 mfhi returns HI; 010010 mflo returns LO.
  - 011000 mult (signed), 011001 multu.
  - Any other funct yields 0.
- Arithmetic wraps modulo 2^32; no overflow trap.
- wreg = RegDst ? rd_in : rt_in.
- Latency: one cycle. All EX/MEM outputs update at the rising edge following valid ID/EX inputs.
- FSM IDLE:
  - If ALUOp=10 and funct is mult/multu: stall_o=1.
  - Latch |A| and |B| (or raw values for multu), latch the sign-xor, clear the 64-bit accumulator, counter=0, go to BUSY.
  - EX/MEM receives a bubble: wb=0, mem=0, all other fields 0.
- FSM BUSY:
  - Each cycle performs one shift-add iteration, counter+1.
  - stall_o=1 while counter<XLEN-1. EX/MEM receives a bubble every BUSY cycle.
- Final iteration (counter==XLEN-1):
  - stall_o=0.
  - The accumulator is finalised combinationally, negated if signed with sign-xor=1.
  - {HI,LO} is written at that edge, state returns to IDLE, and ID/EX advances on the same edge.
- Total stall: XLEN cycles. The mult occupies EX for XLEN+1 cycles and retires as a bubble with no register write.
- mfhi/mflo immediately after a mult reads the updated HI/LO; no extra stall is required.
- A mult never re-triggers, because ID/EX has advanced by the time IDLE is re-entered.
- Reset mid-multiply: operation aborts immediately (async), HI/LO return to 0, stall_o drops in the same cycle.
- Non-mult instructions never assert stall_o.

Decomposition:
- Shared package holds:
  - ALUOp encodings and funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_MULT, FN_MULTU, FN_MFHI, FN_MFLO).
  - Control-bit index constants for wb/mem/ex.
  - FSM state typedef {IDLE, BUSY}.
- One natural sub-module: seq_multiplier. It owns the operands, accumulator, counter and FSM, with start/signed/busy/last/product ports.
- ALU, ALU-control decode, HI/LO and the EX/MEM register stay in the top module.

Test Plan:
- R-type add, rd1=5, rd2=7, RegDst=1, rd=3, RegWrite=1 → next edge: alu_out=12, wreg_out=3, wb_out=2'b10, zero_out=0, stall_o never high.
- beq-style ALUOp=01, rd1=rd2=0x1234, npc=0x100, imm=4 → alu_out=0, zero_out=1, br_tgt_out=0x110, mem_out[2]=1.
- mult rd1=-3, rd2=7 → stall_o high exactly 32 cycles, 32 bubbles on EX/MEM (wb_out=0), then HI=0xFFFFFFFF, LO=0xFFFFFFEB; a following mfhi yields 0xFFFFFFFF and mflo yields 0xFFFFFFEB.
- multu 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; same operands with mult → HI=0, LO=1.
- slt rd1=0xFFFFFFFF, rd2=1 → alu_out=1; ALUSrc=1 with ALUOp=00, rd1=0x10, imm=0xFFFFFFFC → alu_out=0xC.
- Assert rst during cycle 10 of a mult → stall_o=0, all outputs 0 and HI=LO=0 before the next edge; after release, an add executes normally with no stall.

Source files
------------

// File: rtl/ex_stage_muldiv_pkg.sv
// Shared encodings for the MIPS execute stage: ALUOp/funct codes, control-bit
// positions and the multiplier FSM state type.
package ex_stage_muldiv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 5;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;

    localparam int WB_REGWRITE  = 1;
    localparam int WB_MEMTOREG  = 0;
    localparam int MEM_BRANCH   = 2;
    localparam int MEM_MEMREAD  = 1;
    localparam int MEM_MEMWRITE = 0;
    localparam int EX_REGDST    = 3;
    localparam int EX_ALUOP_HI  = 2;
    localparam int EX_ALUOP_LO  = 1;
    localparam int EX_ALUSRC    = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_t;

    function automatic logic is_mult_op(input logic [1:0] alu_op, input logic [5:0] funct);
        return (alu_op == ALUOP_RTYPE) && ((funct == FN_MULT) || (funct == FN_MULTU));
    endfunction

endpackage

// File: rtl/ex_stage_muldiv_seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle over XLEN cycles,
// operating on magnitudes with the sign restored on the final iteration.
module seq_multiplier
    import ex_stage_muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_signed,
    input  logic [XLEN-1:0]     i_a,
    input  logic [XLEN-1:0]     i_b,
    output logic                o_busy,
    output logic                o_last,
    output logic [2*XLEN-1:0]   o_product
);

    mul_state_t         r_state;
    mul_state_t         w_state_next;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic               r_neg;
    logic [2*XLEN-1:0]  r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*XLEN-1:0]  w_acc_next;
    logic [XLEN-1:0]    w_a_mag;
    logic [XLEN-1:0]    w_b_mag;
    logic               w_cnt_last;

    assign w_cnt_last = (r_cnt == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = BUSY;
            BUSY:    if (w_cnt_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == BUSY);
        o_last = (r_state == BUSY) && w_cnt_last;
    end

    // Magnitude of -2^(XLEN-1) is 2^(XLEN-1), which still fits unsigned.
    assign w_a_mag = (i_signed && i_a[XLEN-1]) ? -i_a : i_a;
    assign w_b_mag = (i_signed && i_b[XLEN-1]) ? -i_b : i_b;

    assign w_acc_next = r_acc + (r_b[r_cnt] ? ({{XLEN{1'b0}}, r_a} << r_cnt) : '0);
    assign o_product  = r_neg ? -w_acc_next : w_acc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_neg <= 1'b0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (i_start) begin
                r_a   <= w_a_mag;
                r_b   <= w_b_mag;
                r_neg <= i_signed && (i_a[XLEN-1] ^ i_b[XLEN-1]);
                r_acc <= '0;
                r_cnt <= '0;
            end
        end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ex_stage_muldiv.sv
// MIPS execute stage: ALU, ALU control, branch target, dest-reg mux, HI/LO and
// EX/MEM register; MULT/MULTU stall upstream while the multiplier iterates.
module ex_stage_muldiv
    import ex_stage_muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      wb_in,
    input  logic [2:0]      mem_in,
    input  logic [3:0]      ex_in,
    input  logic [XLEN-1:0] npc_in,
    input  logic [XLEN-1:0] rd1_in,
    input  logic [XLEN-1:0] rd2_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [4:0]      rt_in,
    input  logic [4:0]      rd_in,
    input  logic [5:0]      funct_in,
    output logic            stall_o,
    output logic [1:0]      wb_out,
    output logic [2:0]      mem_out,
    output logic [XLEN-1:0] br_tgt_out,
    output logic            zero_out,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] rd2_out,
    output logic [4:0]      wreg_out
);

    logic [1:0]         w_alu_op;
    logic [XLEN-1:0]    w_a;
    logic [XLEN-1:0]    w_b;
    logic [XLEN-1:0]    w_alu_res;
    logic [4:0]         w_wreg;
    logic               w_is_mult;
    logic               w_mul_start;
    logic               w_mul_busy;
    logic               w_mul_last;
    logic               w_bubble;
    logic [2*XLEN-1:0]  w_product;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;

    assign w_alu_op    = ex_in[EX_ALUOP_HI:EX_ALUOP_LO];
    assign w_a         = rd1_in;
    assign w_b         = ex_in[EX_ALUSRC] ? imm_in : rd2_in;
    assign w_wreg      = ex_in[EX_REGDST] ? rd_in : rt_in;
    assign w_is_mult   = is_mult_op(w_alu_op, funct_in);
    assign w_mul_start = w_is_mult && !w_mul_busy;
    assign w_bubble    = w_is_mult || w_mul_busy;
    // The final iteration releases the pipeline so ID/EX advances on the HI/LO write edge.
    assign stall_o     = !rst && (w_mul_start || (w_mul_busy && !w_mul_last));

    seq_multiplier #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_signed  (funct_in == FN_MULT),
        .i_a       (rd1_in),
        .i_b       (rd2_in),
        .o_busy    (w_mul_busy),
        .o_last    (w_mul_last),
        .o_product (w_product)
    );

    always_comb begin
        w_alu_res = '0;
        case (w_alu_op)
            ALUOP_ADD: w_alu_res = w_a + w_b;
            ALUOP_SUB: w_alu_res = w_a - w_b;
            ALUOP_OR:  w_alu_res = w_a | w_b;
            default: begin
                case (funct_in)
                    FN_ADD:  w_alu_res = w_a + w_b;
                    FN_SUB:  w_alu_res = w_a - w_b;
                    FN_AND:  w_alu_res = w_a & w_b;
                    FN_OR:   w_alu_res = w_a | w_b;
                    FN_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
                    FN_MFHI: w_alu_res = r_hi;
                    FN_MFLO: w_alu_res = r_lo;
                    default: w_alu_res = '0;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_mul_last) begin
            r_hi <= w_product[2*XLEN-1:XLEN];
            r_lo <= w_product[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_out     <= '0;
            mem_out    <= '0;
            br_tgt_out <= '0;
            zero_out   <= 1'b0;
            alu_out    <= '0;
            rd2_out    <= '0;
            wreg_out   <= '0;
        end else if (w_bubble) begin
            wb_out     <= '0;
            mem_out    <= '0;
            br_tgt_out <= '0;
            zero_out   <= 1'b0;
            alu_out    <= '0;
            rd2_out    <= '0;
            wreg_out   <= '0;
        end else begin
            wb_out     <= wb_in;
            mem_out    <= mem_in;
            br_tgt_out <= npc_in + (imm_in << 2);
            zero_out   <= (w_alu_res == '0);
            alu_out    <= w_alu_res;
            rd2_out    <= rd2_in;
            wreg_out   <= w_wreg;
        end
    end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Self-checking bench for ex_stage_muldiv: directed and random ALU ops, mult/multu
// stall timing, HI/LO readback and asynchronous reset during a multiply.
module tb_ex_stage_muldiv;

    localparam logic [5:0] T_ADD = 6'b100000, T_SUB = 6'b100010, T_AND = 6'b100100;
    localparam logic [5:0] T_OR = 6'b100101, T_SLT = 6'b101010, T_MFHI = 6'b010000;
    localparam logic [5:0] T_MFLO = 6'b010010, T_MULT = 6'b011000, T_MULTU = 6'b011001;

    logic        clk, rst;
    logic [1:0]  wb_in;
    logic [2:0]  mem_in;
    logic [3:0]  ex_in;
    logic [31:0] npc_in, rd1_in, rd2_in, imm_in;
    logic [4:0]  rt_in, rd_in;
    logic [5:0]  funct_in;
    logic        stall_o;
    logic [1:0]  wb_out;
    logic [2:0]  mem_out;
    logic [31:0] br_tgt_out, alu_out, rd2_out;
    logic        zero_out;
    logic [4:0]  wreg_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    ex_stage_muldiv dut (
        .clk(clk), .rst(rst), .wb_in(wb_in), .mem_in(mem_in), .ex_in(ex_in),
        .npc_in(npc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rt_in(rt_in), .rd_in(rd_in), .funct_in(funct_in), .stall_o(stall_o),
        .wb_out(wb_out), .mem_out(mem_out), .br_tgt_out(br_tgt_out),
        .zero_out(zero_out), .alu_out(alu_out), .rd2_out(rd2_out), .wreg_out(wreg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: behaviour of each ALUOp/funct in plain arithmetic.
    function automatic logic [31:0] model_alu(input logic [3:0] ex, input logic [31:0] a,
                                              input logic [31:0] rd2, input logic [31:0] imm,
                                              input logic [5:0] fn);
        logic [31:0] b;
        b = ex[0] ? imm : rd2;
        case (ex[2:1])
            2'b00: return a + b;
            2'b01: return a - b;
            2'b11: return a | b;
            default: begin
                if (fn == T_ADD)  return a + b;
                if (fn == T_SUB)  return a - b;
                if (fn == T_AND)  return a & b;
                if (fn == T_OR)   return a | b;
                if (fn == T_SLT)  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                if (fn == T_MFHI) return m_hi;
                if (fn == T_MFLO) return m_lo;
                return 32'd0;
            end
        endcase
    endfunction

    task automatic drive(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] ex,
                         input logic [31:0] npc, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [5:0] fn);
        wb_in = wb; mem_in = mem; ex_in = ex; npc_in = npc; rd1_in = rd1; rd2_in = rd2;
        imm_in = imm; rt_in = rt; rd_in = rd; funct_in = fn;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(2'b11, 3'b111, 4'b1100, 32'h40, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, T_MULT);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (stall_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_o);
        end
        n_checks++;
        if ({wb_out, mem_out, br_tgt_out, zero_out, alu_out, rd2_out, wreg_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wb=%b mem=%b br=%h z=%b alu=%h rd2=%h wreg=%0d expected all 0",
                     wb_out, mem_out, br_tgt_out, zero_out, alu_out, rd2_out, wreg_out);
        end
        drive(2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 6'd0);
        rst = 1'b0;
        $display("reset: stall=%b alu=%h", stall_o, alu_out);
    endtask

    typedef struct {
        logic [1:0] wb; logic [2:0] mem; logic [3:0] ex;
        logic [31:0] npc, rd1, rd2, imm; logic [4:0] rt, rd; logic [5:0] fn;
        logic [31:0] e_alu; logic e_zero; logic [31:0] e_br; logic [4:0] e_wreg;
    } vec_t;

    task automatic test_directed();
        vec_t dv[6];
        dv[0] = '{2'b10, 3'b000, 4'b1100, 32'h0, 32'd5, 32'd7, 32'h0, 5'd9, 5'd3, T_ADD,
                  32'd12, 1'b0, 32'h0, 5'd3};
        dv[1] = '{2'b00, 3'b100, 4'b0010, 32'h100, 32'h1234, 32'h1234, 32'd4, 5'd4, 5'd0, 6'd0,
                  32'd0, 1'b1, 32'h110, 5'd4};
        dv[2] = '{2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 5'd1, 5'd5, T_SLT,
                  32'd1, 1'b0, 32'h0, 5'd5};
        dv[3] = '{2'b10, 3'b000, 4'b0001, 32'h200, 32'h10, 32'h55, 32'hFFFFFFFC, 5'd8, 5'd1, 6'd0,
                  32'hC, 1'b0, 32'h1F0, 5'd8};
        dv[4] = '{2'b10, 3'b000, 4'b1100, 32'h0, 32'd3, 32'd4, 32'h0, 5'd2, 5'd6, 6'b000111,
                  32'd0, 1'b1, 32'h0, 5'd6};
        dv[5] = '{2'b10, 3'b010, 4'b0111, 32'h4, 32'hF0, 32'h0, 32'h0F, 5'd7, 5'd0, 6'd0,
                  32'hFF, 1'b0, 32'h40, 5'd7};
        for (int i = 0; i < 6; i++) begin
            drive(dv[i].wb, dv[i].mem, dv[i].ex, dv[i].npc, dv[i].rd1, dv[i].rd2, dv[i].imm,
                  dv[i].rt, dv[i].rd, dv[i].fn);
            n_checks++;
            if (stall_o !== 1'b0) begin
                n_fail++; $display("FAIL dir%0d_stall: got %b expected 0", i, stall_o);
            end
            @(posedge clk); #1;
            n_checks++;
            if (alu_out !== dv[i].e_alu || zero_out !== dv[i].e_zero) begin
                n_fail++;
                $display("FAIL dir%0d_alu: got alu=%h zero=%b expected alu=%h zero=%b",
                         i, alu_out, zero_out, dv[i].e_alu, dv[i].e_zero);
            end
            n_checks++;
            if ({wb_out, mem_out, br_tgt_out, wreg_out, rd2_out} !==
                {dv[i].wb, dv[i].mem, dv[i].e_br, dv[i].e_wreg, dv[i].rd2}) begin
                n_fail++;
                $display("FAIL dir%0d_fields: got wb=%b mem=%b br=%h wreg=%0d rd2=%h expected wb=%b mem=%b br=%h wreg=%0d rd2=%h",
                         i, wb_out, mem_out, br_tgt_out, wreg_out, rd2_out,
                         dv[i].wb, dv[i].mem, dv[i].e_br, dv[i].e_wreg, dv[i].rd2);
            end
            $display("directed %0d: alu=%h zero=%b br=%h wreg=%0d", i, alu_out, zero_out, br_tgt_out, wreg_out);
        end
    endtask

    task automatic test_random_alu(input int n);
        logic [5:0]  fns[8];
        logic [1:0]  wb; logic [2:0] mem; logic [3:0] ex; logic [5:0] fn;
        logic [31:0] npc, a, b, imm, e_alu; logic [4:0] rt, rd;
        for (int i = 0; i < n; i++) begin
            fns = '{T_ADD, T_SUB, T_AND, T_OR, T_SLT, T_MFHI, T_MFLO, 6'($urandom)};
            fn = fns[$urandom_range(0, 7)];
            ex = 4'($urandom);
            if (ex[2:1] == 2'b10 && (fn == T_MULT || fn == T_MULTU)) fn = 6'd0;
            wb = 2'($urandom); mem = 3'($urandom);
            npc = $urandom; a = $urandom; b = $urandom; imm = $urandom;
            if (i % 5 == 0) b = a;
            rt = 5'($urandom); rd = 5'($urandom);
            e_alu = model_alu(ex, a, b, imm, fn);
            drive(wb, mem, ex, npc, a, b, imm, rt, rd, fn);
            n_checks++;
            if (stall_o !== 1'b0) begin
                n_fail++; $display("FAIL rnd%0d_stall: got %b expected 0", i, stall_o);
            end
            @(posedge clk); #1;
            n_checks++;
            if (alu_out !== e_alu || zero_out !== (e_alu == 32'd0)) begin
                n_fail++;
                $display("FAIL rnd%0d_alu: ex=%b fn=%b got alu=%h zero=%b expected alu=%h zero=%b",
                         i, ex, fn, alu_out, zero_out, e_alu, (e_alu == 32'd0));
            end
            n_checks++;
            if ({wb_out, mem_out, br_tgt_out, wreg_out, rd2_out} !==
                {wb, mem, npc + imm * 32'd4, (ex[3] ? rd : rt), b}) begin
                n_fail++;
                $display("FAIL rnd%0d_fields: got wb=%b mem=%b br=%h wreg=%0d rd2=%h expected wb=%b mem=%b br=%h wreg=%0d rd2=%h",
                         i, wb_out, mem_out, br_tgt_out, wreg_out, rd2_out,
                         wb, mem, npc + imm * 32'd4, (ex[3] ? rd : rt), b);
            end
            $display("random %0d: ex=%b fn=%b alu=%h", i, ex, fn, alu_out);
        end
    endtask

    task automatic test_mult(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [63:0] prod;
        longint      sa, sb;
        int          n_stall;
        if (sgn) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            prod = 64'(sa * sb);
        end else begin
            prod = {32'd0, a} * {32'd0, b};
        end
        drive(2'b10, 3'b011, 4'b1100, 32'h80, a, b, 32'h5, 5'd2, 5'd4, sgn ? T_MULT : T_MULTU);
        n_stall = 0;
        while (stall_o === 1'b1 && n_stall < 64) begin
            @(posedge clk); #1;
            n_stall++;
            n_checks++;
            if ({wb_out, mem_out, alu_out, wreg_out} !== '0) begin
                n_fail++;
                $display("FAIL mult_bubble%0d: got wb=%b mem=%b alu=%h wreg=%0d expected all 0",
                         n_stall, wb_out, mem_out, alu_out, wreg_out);
            end
        end
        n_checks++;
        if (n_stall != 32) begin
            n_fail++; $display("FAIL mult_stall_len: got %0d cycles expected 32", n_stall);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({wb_out, mem_out, alu_out} !== '0) begin
            n_fail++;
            $display("FAIL mult_retire: got wb=%b mem=%b alu=%h expected bubble", wb_out, mem_out, alu_out);
        end
        m_hi = prod[63:32]; m_lo = prod[31:0];
        for (int k = 0; k < 2; k++) begin
            drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd8, k == 0 ? T_MFHI : T_MFLO);
            n_checks++;
            if (stall_o !== 1'b0) begin
                n_fail++; $display("FAIL mf%0d_stall: got %b expected 0", k, stall_o);
            end
            @(posedge clk); #1;
            n_checks++;
            if (alu_out !== (k == 0 ? m_hi : m_lo) || wb_out !== 2'b10) begin
                n_fail++;
                $display("FAIL %s: a=%h b=%h sgn=%b got %h wb=%b expected %h wb=10",
                         k == 0 ? "mfhi" : "mflo", a, b, sgn, alu_out, wb_out, k == 0 ? m_hi : m_lo);
            end
        end
        $display("mult a=%h b=%h sgn=%b: stall=%0d hi=%h lo=%h", a, b, sgn, n_stall, m_hi, m_lo);
    endtask

    task automatic test_reset_mid_mult();
        drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'h12345, 32'h6789, 32'h0, 5'd0, 5'd1, T_MULT);
        repeat (10) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (stall_o !== 1'b1) begin
            n_fail++; $display("FAIL midrst_prestall: got %b expected 1", stall_o);
        end
        rst = 1'b1;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        n_checks++;
        if (stall_o !== 1'b0) begin
            n_fail++; $display("FAIL midrst_stall: got %b expected 0", stall_o);
        end
        n_checks++;
        if ({wb_out, mem_out, br_tgt_out, zero_out, alu_out, rd2_out, wreg_out} !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: got alu=%h wb=%b expected all 0", alu_out, wb_out);
        end
        drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'd5, 32'd7, 32'h0, 5'd0, 5'd3, T_ADD);
        rst = 1'b0;
        #1;
        n_checks++;
        if (stall_o !== 1'b0) begin
            n_fail++; $display("FAIL postrst_stall: got %b expected 0", stall_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if (alu_out !== 32'd12 || wreg_out !== 5'd3) begin
            n_fail++; $display("FAIL postrst_add: got alu=%h wreg=%0d expected alu=0000000c wreg=3", alu_out, wreg_out);
        end
        for (int k = 0; k < 2; k++) begin
            drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd8, k == 0 ? T_MFHI : T_MFLO);
            @(posedge clk); #1;
            n_checks++;
            if (alu_out !== 32'd0) begin
                n_fail++; $display("FAIL postrst_hilo%0d: got %h expected 00000000", k, alu_out);
            end
        end
        $display("reset mid-mult: post add alu=12 checked, hi/lo cleared");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mult(32'hFFFFFFFD, 32'd7, 1'b1);
        test_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        test_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        test_random_alu(40);
        for (int i = 0; i < 4; i++) test_mult($urandom, $urandom, 1'(i % 2));
        test_mult(32'h80000000, 32'h80000000, 1'b1);
        test_random_alu(10);
        test_reset_mid_mult();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
